// File: rtl/cga_bus_front.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// cga_bus_front
// ISA bus front end for a CGA-compatible display card. It synchronises the
// bus strobes and vsync, decodes the I/O register block and the framebuffer
// window, holds the mode/colour/extension registers, and muxes read data back
// onto the bus. It also optionally stretches framebuffer accesses with
// IOCHRDY until the sequencer reaches a free slot, and generates the cursor
// and character blink phases.
//
// Optional feature: define CGA_BUS_WAIT_EN to build the IOCHRDY wait FSM.
// Without it bus_rdy is tied high and clk_seq is ignored.
//
// I/O map (relative to IO_BASE_ADDR):
//   +0..+7  CRTC (reads return crtc_rdata on odd addresses)
//   +8      control (mode) register, write-only
//   +9      colour register, write-only
//   +A      status register, read-only
//   +B..    extension mode registers, write-only, NUM_EXT_REGS of them
//
// Ports:
//   clk, reset              single clock; asynchronous active-high reset
//   bus_a, bus_d            ISA address and write data
//   bus_ior_l .. bus_memw_l active-low ISA strobes
//   bus_aen                 DMA address enable (blocks I/O decode)
//   mem_rdata, crtc_rdata   read data from VRAM and from the CRTC
//   vsync_l, display_enable CRTC timing, feeds the status register
//   clk_seq                 sequencer slot counter
//   bus_out, bus_dir        read data and transceiver direction (1 = card drives)
//   bus_rdy                 IOCHRDY
//   crtc_cs/wr/rd           qualified CRTC strobes
//   mem_rd, mem_wr          qualified VRAM strobes
//   control_reg, color_reg  mode and colour registers
//   ext_regs                extension registers, byte i at [8*i +: 8]
//   blink_fast, blink_slow  cursor and character blink phases
// -----------------------------------------------------------------------------
module cga_bus_front #(
    parameter logic [19:0] IO_BASE_ADDR    = 20'h3D0,
    parameter logic [19:0] FB_ADDR         = 20'hB8000,
    parameter int          FB_SIZE_LOG2    = 15,
    parameter int          NUM_EXT_REGS    = 2,
    parameter logic [4:0]  WAIT_START_SLOT = 5'd17,
    parameter logic [4:0]  WAIT_END_SLOT   = 5'd20,
    parameter logic [23:0] BLINK_MAX       = 24'd3_579_544
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [19:0]               bus_a,
    input  logic [7:0]                bus_d,
    input  logic                      bus_ior_l,
    input  logic                      bus_iow_l,
    input  logic                      bus_memr_l,
    input  logic                      bus_memw_l,
    input  logic                      bus_aen,
    input  logic [7:0]                mem_rdata,
    input  logic [7:0]                crtc_rdata,
    input  logic                      vsync_l,
    input  logic                      display_enable,
    input  logic [4:0]                clk_seq,
    output logic [7:0]                bus_out,
    output logic                      bus_dir,
    output logic                      bus_rdy,
    output logic                      crtc_cs,
    output logic                      crtc_wr,
    output logic                      crtc_rd,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [7:0]                control_reg,
    output logic [7:0]                color_reg,
    output logic [8*NUM_EXT_REGS-1:0] ext_regs,
    output logic                      blink_fast,
    output logic                      blink_slow
);

    localparam int S_IOR   = 0;
    localparam int S_IOW   = 1;
    localparam int S_MEMR  = 2;
    localparam int S_MEMW  = 3;
    localparam int S_VSYNC = 4;
    localparam int EXT_N   = (NUM_EXT_REGS > 0) ? NUM_EXT_REGS : 1;

    // ---------------------------------------------------------------- sync
    logic [4:0] sync_raw;
    logic [4:0] sync_q1;
    logic [4:0] sync_q2;
    logic       iow_q3;     // previous synchronised iow, for edge detect

    assign sync_raw = {vsync_l, bus_memw_l, bus_memr_l, bus_iow_l, bus_ior_l};

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour; blocking here would
        // collapse the two synchroniser stages into one.
        if (reset) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
            iow_q3  <= 1'b1;
        end else begin
            sync_q1 <= sync_raw;
            sync_q2 <= sync_q1;
            iow_q3  <= sync_q2[S_IOW];
        end
    end

    logic ior_act;
    logic iow_act;
    logic memr_act;
    logic memw_act;
    logic wr_edge;

    assign ior_act  = ~sync_q2[S_IOR];
    assign iow_act  = ~sync_q2[S_IOW];
    assign memr_act = ~sync_q2[S_MEMR];
    assign memw_act = ~sync_q2[S_MEMW];
    // One-cycle pulse on the synchronised falling edge: a long strobe writes once.
    assign wr_edge  = iow_act & iow_q3;

    // -------------------------------------------------------------- decode
    logic [19:0] io_off;
    logic [3:0]  io_idx;
    logic        io_hit;
    logic        crtc_hit;
    logic        mem_hit;

    // Subtracting the base handles any base alignment; addresses below the
    // base wrap to large offsets and miss.
    assign io_off   = bus_a - IO_BASE_ADDR;
    assign io_idx   = io_off[3:0];
    assign io_hit   = !bus_aen && (io_off[19:4] == 16'h0000);
    assign crtc_hit = io_hit && !io_idx[3];
    assign mem_hit  = (bus_a[19:FB_SIZE_LOG2] == FB_ADDR[19:FB_SIZE_LOG2]);

    assign crtc_cs = crtc_hit && (ior_act || iow_act);
    assign crtc_rd = crtc_hit && ior_act;
    assign crtc_wr = crtc_hit && iow_act;
    assign mem_rd  = mem_hit && memr_act;
    assign mem_wr  = mem_hit && memw_act;

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control_reg <= 8'h28;
            color_reg   <= 8'h00;
        end else if (wr_edge && io_hit) begin
            case (io_idx)
                4'h8:    control_reg <= bus_d;
                4'h9:    color_reg   <= bus_d;
                default: ;
            endcase
        end
    end

    logic [7:0] ext_q [EXT_N];

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: this array is a handful of mode bytes that must come up
        // defined, so it is reset like ordinary flops; a real RAM would not be.
        if (reset) begin
            for (int i = 0; i < EXT_N; i++) ext_q[i] <= 8'h00;
        end else if (wr_edge && io_hit) begin
            for (int i = 0; i < NUM_EXT_REGS; i++) begin
                if (io_idx == 4'(11 + i)) ext_q[i] <= bus_d;
            end
        end
    end

    generate
        if (NUM_EXT_REGS > 0) begin : g_ext
            for (genvar i = 0; i < NUM_EXT_REGS; i++) begin : g_byte
                assign ext_regs[8*i +: 8] = ext_q[i];
            end
        end else begin : g_no_ext
            assign ext_regs = '0;
        end
    endgenerate

    // ------------------------------------------------------------ read mux
    logic [7:0] status_byte;
    logic       mem_rd_sel;
    logic       status_sel;
    logic       crtc_rd_sel;

    assign status_byte = {4'b1111, sync_q2[S_VSYNC], 2'b10, ~display_enable};
    assign mem_rd_sel  = mem_hit && memr_act;
    assign status_sel  = io_hit && ior_act && (io_idx == 4'hA);
    // The CRTC index register (even address) is write-only.
    assign crtc_rd_sel = crtc_hit && ior_act && bus_a[0];

    always_comb begin
        // NOTE: default first so every path assigns bus_out and no latch forms.
        bus_out = 8'h00;
        if (mem_rd_sel)       bus_out = mem_rdata;
        else if (status_sel)  bus_out = status_byte;
        else if (crtc_rd_sel) bus_out = crtc_rdata;
    end

    assign bus_dir = mem_rd_sel || status_sel || crtc_rd_sel;

    // ------------------------------------------------------------ wait FSM
`ifdef CGA_BUS_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, READY} wait_state_t;

    wait_state_t wait_state;
    logic        mem_access;

    assign mem_access = mem_hit && (memr_act || memw_act);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_state <= IDLE;
        end else begin
            case (wait_state)
                IDLE:    if (mem_access) wait_state <= WAIT_A;
                WAIT_A:  if (!mem_access)                    wait_state <= IDLE;
                         else if (clk_seq == WAIT_START_SLOT) wait_state <= WAIT_B;
                WAIT_B:  if (!mem_access)                    wait_state <= IDLE;
                         else if (clk_seq == WAIT_END_SLOT)   wait_state <= READY;
                READY:   if (!mem_access) wait_state <= IDLE;
                default: wait_state <= IDLE;
            endcase
        end
    end

    // Ready must fall in the same cycle the access is seen, before the FSM
    // has had a clock to leave IDLE, or the bus cycle would complete early.
    assign bus_rdy = (wait_state == READY) || ((wait_state == IDLE) && !mem_access);
`else
    logic unused_wait;
    assign unused_wait = ^{clk_seq, WAIT_START_SLOT, WAIT_END_SLOT};
    assign bus_rdy     = 1'b1;
`endif

    // --------------------------------------------------------------- blink
    logic [23:0] blink_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt  <= 24'd0;
            blink_fast <= 1'b0;
            blink_slow <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt  <= 24'd0;
            blink_fast <= ~blink_fast;
            // Toggle on the fast rising edge only: half the fast rate.
            if (!blink_fast) blink_slow <= ~blink_slow;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end

endmodule

// File: tb/tb_cga_bus_front.sv
`timescale 1ns / 1ps
// Scoreboard bench for cga_bus_front. Stimulus pushes expected values with the
// cycle they fall due; an independent monitor compares them on the falling
// edge and also times the blink outputs.
module tb_cga_bus_front;

`ifdef CGA_BUS_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam logic [15:0] RDY_WAIT = WAIT_EN ? 16'h0000 : 16'h0001;
    localparam logic [19:0] IO = 20'h3D0;

    logic        clk;
    logic        reset;
    logic [19:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen;
    logic [7:0]  mem_rdata, crtc_rdata;
    logic        vsync_l, display_enable;
    logic [4:0]  clk_seq = 5'd0;
    logic [7:0]  bus_out;
    logic        bus_dir, bus_rdy;
    logic        crtc_cs, crtc_wr, crtc_rd, mem_rd, mem_wr;
    logic [7:0]  control_reg, color_reg;
    logic [15:0] ext_regs;
    logic        blink_fast, blink_slow;

    cga_bus_front #(.BLINK_MAX(24'd3)) dut (
        .clk(clk), .reset(reset),
        .bus_a(bus_a), .bus_d(bus_d),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_aen(bus_aen),
        .mem_rdata(mem_rdata), .crtc_rdata(crtc_rdata),
        .vsync_l(vsync_l), .display_enable(display_enable), .clk_seq(clk_seq),
        .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
        .crtc_cs(crtc_cs), .crtc_wr(crtc_wr), .crtc_rd(crtc_rd),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .control_reg(control_reg), .color_reg(color_reg), .ext_regs(ext_regs),
        .blink_fast(blink_fast), .blink_slow(blink_slow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    // Free-running sequencer slot counter, updated like a flop on the edge.
    always @(posedge clk) clk_seq <= clk_seq + 5'd1;

    typedef enum {K_OUT, K_DIR, K_RDY, K_CTRL, K_COLOR, K_EXT, K_CS,
                  K_CRD, K_CWR, K_MRD, K_MWR, K_BF, K_BS} kind_t;
    typedef struct {
        kind_t       kind;
        logic [15:0] exp;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;
    bit   blink_arm = 1'b0;
    int   rel_cyc = 0;

    function automatic logic [15:0] observe(kind_t k);
        case (k)
            K_OUT:   return {8'h00, bus_out};
            K_DIR:   return {15'h0, bus_dir};
            K_RDY:   return {15'h0, bus_rdy};
            K_CTRL:  return {8'h00, control_reg};
            K_COLOR: return {8'h00, color_reg};
            K_EXT:   return ext_regs;
            K_CS:    return {15'h0, crtc_cs};
            K_CRD:   return {15'h0, crtc_rd};
            K_CWR:   return {15'h0, crtc_wr};
            K_MRD:   return {15'h0, mem_rd};
            K_MWR:   return {15'h0, mem_wr};
            K_BF:    return {15'h0, blink_fast};
            K_BS:    return {15'h0, blink_slow};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Expectation due on the falling edge d cycles from now.
    task automatic exp_at(kind_t k, logic [15:0] v, int d, string nm);
        exp_t e;
        e.kind = k; e.exp = v; e.due = cyc + d; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(logic [4:0] s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (clk_seq == s) found = 1'b1;
            else tick(1);
        end
        if (!found) begin
            $display("FAIL wait_slot: slot %0d never seen", s);
            $fatal(1);
        end
    endtask

    task automatic pulse_iow(logic [19:0] a, logic [7:0] d);
        bus_a = a; bus_d = d; bus_iow_l = 1'b0;
        tick(4);
        bus_iow_l = 1'b1;
        tick(4);
    endtask

    // ------------------------------------------------------------- monitor
    initial begin
        exp_t        e;
        logic [15:0] got;
        logic        bf_prev, bs_prev;
        int          bf_seen, bs_seen, bf_last, bs_last;
        bf_prev = 1'b0; bs_prev = 1'b0;
        bf_seen = 0; bs_seen = 0; bf_last = 0; bs_last = 0;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    e = sb[i];
                    got = observe(e.kind);
                    n_cmp++;
                    if (got !== e.exp) begin
                        n_bad++;
                        $display("FAIL %s: got %h, required %h (cycle %0d)",
                                 e.name, got, e.exp, cyc);
                    end
                    sb.delete(i);
                end
            end
            if (blink_arm) begin
                if (blink_fast !== bf_prev) begin
                    if (bf_seen == 0) bf_last = rel_cyc;
                    if (bf_seen < 8) begin
                        n_cmp++;
                        if (cyc - bf_last != 4) begin
                            n_bad++;
                            $display("FAIL blink_fast_period: got %0d clk, required 4", cyc - bf_last);
                        end
                    end
                    bf_seen++;
                    bf_last = cyc;
                end
                if (blink_slow !== bs_prev) begin
                    if (bs_seen >= 1 && bs_seen < 5) begin
                        n_cmp++;
                        if (cyc - bs_last != 8) begin
                            n_bad++;
                            $display("FAIL blink_slow_period: got %0d clk, required 8", cyc - bs_last);
                        end
                    end
                    bs_seen++;
                    bs_last = cyc;
                end
            end
            bf_prev = blink_fast;
            bs_prev = blink_slow;
            if (done) begin
                for (int i = 0; i < sb.size(); i++) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: never compared, required %h", sb[i].name, sb[i].exp);
                end
                n_cmp++;
                if (bf_seen < 8) begin
                    n_bad++;
                    $display("FAIL blink_fast_toggles: got %0d, required at least 8", bf_seen);
                end
                n_cmp++;
                if (bs_seen < 5) begin
                    n_bad++;
                    $display("FAIL blink_slow_toggles: got %0d, required at least 5", bs_seen);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        reset = 1'b1;
        bus_a = 20'h0; bus_d = 8'h00; bus_aen = 1'b0;
        bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
        mem_rdata = 8'h00; crtc_rdata = 8'h00;
        vsync_l = 1'b1; display_enable = 1'b1;
        tick(3);

        // Reset state
        exp_at(K_CTRL, 16'h0028, 0, "rst_control");
        exp_at(K_COLOR, 16'h0000, 0, "rst_color");
        exp_at(K_EXT, 16'h0000, 0, "rst_ext");
        exp_at(K_RDY, 16'h0001, 0, "rst_rdy");
        exp_at(K_DIR, 16'h0000, 0, "rst_dir");
        exp_at(K_BF, 16'h0000, 0, "rst_blink_fast");
        exp_at(K_BS, 16'h0000, 0, "rst_blink_slow");
        tick(1);
        reset = 1'b0;
        rel_cyc = cyc;
        blink_arm = 1'b1;

        // Status read: FC with de=1, vsync high; F4 two clocks after vsync low
        bus_a = IO + 20'hA; bus_ior_l = 1'b0;
        exp_at(K_OUT, 16'h0000, 1, "status_presync");
        exp_at(K_OUT, 16'h00FC, 2, "status_de1");
        exp_at(K_DIR, 16'h0001, 2, "status_dir");
        tick(3);
        vsync_l = 1'b0;
        exp_at(K_OUT, 16'h00FC, 1, "status_vsync_lag");
        exp_at(K_OUT, 16'h00F4, 2, "status_vsync0");
        tick(3);
        bus_ior_l = 1'b1; vsync_l = 1'b1;
        tick(3);

        // Control write, strobe held 20 clk, single write
        bus_a = IO + 20'h8; bus_d = 8'h09; bus_iow_l = 1'b0;
        exp_at(K_CTRL, 16'h0028, 2, "ctrl_before_edge");
        exp_at(K_CTRL, 16'h0009, 3, "ctrl_written");
        exp_at(K_CWR, 16'h0000, 3, "ctrl_not_crtc");
        tick(5);
        bus_d = 8'h77;
        tick(15);
        exp_at(K_CTRL, 16'h0009, 0, "ctrl_single_write");
        bus_iow_l = 1'b1;
        tick(4);

        // Colour and extension registers
        exp_at(K_COLOR, 16'h00A5, 3, "color_written");
        pulse_iow(IO + 20'h9, 8'hA5);
        exp_at(K_EXT, 16'h5A00, 3, "ext1_written");
        pulse_iow(IO + 20'hC, 8'h5A);
        exp_at(K_EXT, 16'h5A3C, 3, "ext0_written");
        pulse_iow(IO + 20'hB, 8'h3C);
        exp_at(K_EXT, 16'h5A3C, 4, "ext_idx2_ignored");
        pulse_iow(IO + 20'hD, 8'hFF);
        exp_at(K_EXT, 16'h5A3C, 4, "unmapped_ext");
        exp_at(K_CTRL, 16'h0009, 4, "unmapped_ctrl");
        exp_at(K_COLOR, 16'h00A5, 4, "unmapped_color");
        pulse_iow(IO + 20'hF, 8'h11);

        // Extension read returns 0, card does not drive
        bus_a = IO + 20'hC; bus_ior_l = 1'b0;
        exp_at(K_OUT, 16'h0000, 2, "ext_read_data");
        exp_at(K_DIR, 16'h0000, 2, "ext_read_dir");
        tick(3);
        bus_ior_l = 1'b1;
        tick(3);

        // AEN blocks I/O decode
        bus_aen = 1'b1;
        exp_at(K_CTRL, 16'h0009, 4, "aen_write_ignored");
        pulse_iow(IO + 20'h8, 8'h33);
        bus_a = IO + 20'hA; bus_ior_l = 1'b0;
        exp_at(K_DIR, 16'h0000, 2, "aen_status_dir");
        exp_at(K_OUT, 16'h0000, 2, "aen_status_data");
        tick(3);
        bus_ior_l = 1'b1; bus_aen = 1'b0;
        tick(3);

        // CRTC data read (odd), then index address (even) reads 0
        bus_a = IO + 20'h5; crtc_rdata = 8'h6E; bus_ior_l = 1'b0;
        exp_at(K_OUT, 16'h006E, 2, "crtc_read_data");
        exp_at(K_DIR, 16'h0001, 2, "crtc_read_dir");
        exp_at(K_CRD, 16'h0001, 2, "crtc_rd");
        exp_at(K_CS, 16'h0001, 2, "crtc_cs_read");
        exp_at(K_CWR, 16'h0000, 2, "crtc_wr_idle");
        tick(3);
        bus_a = IO + 20'h4;
        exp_at(K_OUT, 16'h0000, 0, "crtc_index_data");
        exp_at(K_DIR, 16'h0000, 0, "crtc_index_dir");
        tick(1);
        bus_ior_l = 1'b1;
        tick(3);
        bus_iow_l = 1'b0;
        exp_at(K_CWR, 16'h0000, 1, "crtc_wr_presync");
        exp_at(K_CWR, 16'h0001, 2, "crtc_wr");
        exp_at(K_CS, 16'h0001, 2, "crtc_cs_write");
        tick(3);
        bus_iow_l = 1'b1;
        tick(3);

        // Framebuffer read, decoded regardless of AEN
        bus_aen = 1'b1; bus_a = 20'hB8010; mem_rdata = 8'hC3; bus_memr_l = 1'b0;
        exp_at(K_MRD, 16'h0000, 1, "mem_rd_presync");
        exp_at(K_MRD, 16'h0001, 2, "mem_rd_aen");
        exp_at(K_OUT, 16'h00C3, 2, "mem_read_data");
        exp_at(K_DIR, 16'h0001, 2, "mem_read_dir");
        exp_at(K_RDY, RDY_WAIT, 2, "mem_read_rdy");
        tick(3);
        bus_memr_l = 1'b1; bus_aen = 1'b0;
        tick(4);
        // Window edges: BFFFF inside, B7FFF and A0010 outside
        bus_a = 20'hBFFFF; bus_memr_l = 1'b0;
        exp_at(K_MRD, 16'h0001, 2, "mem_window_top");
        tick(3);
        bus_a = 20'hB7FFF;
        exp_at(K_MRD, 16'h0000, 0, "mem_window_below");
        tick(1);
        bus_a = 20'hA0010;
        exp_at(K_DIR, 16'h0000, 0, "mem_outside_dir");
        exp_at(K_RDY, 16'h0001, 2, "mem_outside_rdy");
        tick(3);
        bus_memr_l = 1'b1;
        tick(4);
        bus_a = 20'hB8020; bus_memw_l = 1'b0;
        exp_at(K_MWR, 16'h0001, 2, "mem_wr");
        exp_at(K_DIR, 16'h0000, 2, "mem_wr_dir");
        tick(3);
        bus_memw_l = 1'b1;
        tick(4);

        // Wait window: read from slot 3, ready after slot 20 follows slot 17
        blink_arm = 1'b0;
        wait_slot(5'd3);
        bus_a = 20'hB8010; mem_rdata = 8'h99; bus_memr_l = 1'b0;
        exp_at(K_RDY, 16'h0001, 1, "wait_rdy_presync");
        for (int d = 2; d <= 17; d++) exp_at(K_RDY, RDY_WAIT, d, "wait_rdy_low");
        exp_at(K_RDY, 16'h0001, 18, "wait_rdy_high");
        exp_at(K_OUT, 16'h0099, 18, "wait_read_data");
        exp_at(K_DIR, 16'h0001, 18, "wait_read_dir");
        tick(20);
        bus_memr_l = 1'b1;
        tick(4);
        exp_at(K_RDY, 16'h0001, 0, "wait_after_release");

        // Strobe dropped mid-wait
        wait_slot(5'd3);
        bus_memr_l = 1'b0;
        tick(6);
        bus_memr_l = 1'b1;
        exp_at(K_RDY, RDY_WAIT, 2, "abort_still_wait");
        exp_at(K_RDY, 16'h0001, 3, "abort_rdy_high");
        tick(5);

        // Reset during WAIT_B
        wait_slot(5'd3);
        bus_memr_l = 1'b0;
        tick(15);
        exp_at(K_RDY, RDY_WAIT, 0, "waitb_rdy_low");
        exp_at(K_CTRL, 16'h0009, 0, "waitb_ctrl");
        tick(1);
        reset = 1'b1;
        exp_at(K_RDY, 16'h0001, 0, "reset_rdy_async");
        exp_at(K_CTRL, 16'h0028, 0, "reset_ctrl_async");
        exp_at(K_EXT, 16'h0000, 0, "reset_ext_async");
        bus_memr_l = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(3);

        // Reset discards a pending write edge
        exp_at(K_CTRL, 16'h001A, 3, "ctrl_rewrite");
        pulse_iow(IO + 20'h8, 8'h1A);
        bus_a = IO + 20'h8; bus_d = 8'h55; bus_iow_l = 1'b0;
        tick(2);
        reset = 1'b1;
        bus_iow_l = 1'b1;
        exp_at(K_CTRL, 16'h0028, 0, "discard_reset_ctrl");
        tick(3);
        reset = 1'b0;
        exp_at(K_CTRL, 16'h0028, 4, "discard_no_write");
        tick(6);

        done = 1'b1;
    end

endmodule
